// File: rtl/tennis_pkg.sv
// Shared encodings for the LED tennis ball engine: FSM states, player sides, ball direction.
// Helpers map a direction to the player it approaches, and a side to the direction leaving it.
package tennis_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        RALLY     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_ONE = 1'b0,
        SIDE_TWO = 1'b1
    } side_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic side_t side_toward(input dir_t d);
        return (d == DIR_UP) ? SIDE_TWO : SIDE_ONE;
    endfunction

    function automatic dir_t dir_away(input side_t s);
        return (s == SIDE_ONE) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Game tick generator: tick is high for one clk in every PRESCALE cycles (every cycle when PRESCALE=1).
// Free-running from reset; no handshake, the consumer samples tick as a qualifier.
module tick_prescaler #(
    parameter int PRESCALE = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LP_LAST);

endmodule

// File: rtl/tennis_ball_ctrl.sv
// Ball engine for LED tennis: serve, rally with hit windows and speed-up, point and match handling.
// Optional EARLY_SWING_PENALTY_EN: a receiver press outside the window forfeits the point.
module tennis_ball_ctrl
    import tennis_pkg::*;
#(
    parameter int NUM_LEDS    = 16,
    parameter int PRESCALE    = 1000000,
    parameter int START_TICKS = 20,
    parameter int MIN_TICKS   = 4,
    parameter int SPEED_STEP  = 2,
    parameter int HIT_WINDOW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button_one,
    input  logic                button_two,
    input  logic                match_one,
    input  logic                match_two,
    output logic [NUM_LEDS-1:0] pos,
    output logic                hittable_one,
    output logic                hittable_two,
    output logic                start_game,
    output logic                point_one,
    output logic                point_two
);

    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int PER_W = $clog2(START_TICKS + 1);

    localparam logic [IDX_W-1:0]    LP_LAST    = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0]    LP_HIT_TWO = IDX_W'(NUM_LEDS - HIT_WINDOW);
    localparam logic [IDX_W-1:0]    LP_HIT_ONE = IDX_W'(HIT_WINDOW);
    localparam logic [PER_W-1:0]    LP_START   = PER_W'(START_TICKS);
    localparam logic [PER_W-1:0]    LP_MIN     = PER_W'(MIN_TICKS);
    localparam logic [PER_W-1:0]    LP_STEP    = PER_W'(SPEED_STEP);
    localparam logic [PER_W-1:0]    LP_FLOOR   = PER_W'(MIN_TICKS + SPEED_STEP);
    localparam logic [NUM_LEDS-1:0] LP_ONE     = NUM_LEDS'(1);

    state_t              r_state,  w_state_nxt;
    side_t               r_server, w_server_nxt;
    dir_t                r_dir,    w_dir_nxt;
    logic [IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [PER_W-1:0]    r_period, w_period_nxt;
    logic [PER_W-1:0]    r_step,   w_step_nxt;
    logic                r_btn_one_prev, r_btn_two_prev;
    logic                r_press_one, r_press_two;
    logic [NUM_LEDS-1:0] r_pos;

    logic                w_tick;
    logic                w_step_due;
    logic                w_at_end;
    side_t               w_rcv;
    logic                w_press_srv;
    logic                w_press_rcv;
    logic                w_hit_rcv;
    logic                w_early_swing;
    logic [PER_W-1:0]    w_period_fast;
    logic                w_miss;
    logic                w_start;
    logic                w_point_one;
    logic                w_point_two;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    assign hittable_two = (r_state == RALLY) && (r_dir == DIR_UP)   && (r_idx >= LP_HIT_TWO);
    assign hittable_one = (r_state == RALLY) && (r_dir == DIR_DOWN) && (r_idx <  LP_HIT_ONE);

    assign w_rcv         = side_toward(r_dir);
    assign w_press_srv   = (r_server == SIDE_ONE) ? r_press_one : r_press_two;
    assign w_press_rcv   = (w_rcv == SIDE_ONE) ? r_press_one : r_press_two;
    assign w_hit_rcv     = hittable_one | hittable_two;
    assign w_step_due    = w_tick && (r_step == r_period - 1'b1);
    assign w_at_end      = (r_dir == DIR_UP) ? (r_idx == LP_LAST) : (r_idx == '0);
    assign w_period_fast = (r_period >= LP_FLOOR) ? (r_period - LP_STEP) : LP_MIN;

`ifdef EARLY_SWING_PENALTY_EN
    assign w_early_swing = w_press_rcv && !w_hit_rcv;
`else
    assign w_early_swing = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_server_nxt = r_server;
        w_dir_nxt    = r_dir;
        w_idx_nxt    = r_idx;
        w_period_nxt = r_period;
        w_step_nxt   = r_step;
        w_miss       = 1'b0;
        w_start      = 1'b0;
        w_point_one  = 1'b0;
        w_point_two  = 1'b0;

        case (r_state)
            SERVE: begin
                if (w_press_srv) begin
                    w_start     = 1'b1;
                    w_dir_nxt   = dir_away(r_server);
                    w_step_nxt  = '0;
                    w_state_nxt = RALLY;
                end
            end
            RALLY: begin
                // A legal return beats a step that falls due in the same cycle.
                if (w_press_rcv && w_hit_rcv) begin
                    w_dir_nxt    = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                    w_period_nxt = w_period_fast;
                    w_step_nxt   = '0;
                end else if (w_early_swing) begin
                    w_miss = 1'b1;
                end else if (w_tick) begin
                    if (w_step_due) begin
                        w_step_nxt = '0;
                        if (w_at_end) begin
                            w_miss = 1'b1;
                        end else if (r_dir == DIR_UP) begin
                            w_idx_nxt = r_idx + 1'b1;
                        end else begin
                            w_idx_nxt = r_idx - 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (!match_one && !match_two) begin
                    w_state_nxt  = SERVE;
                    w_server_nxt = SIDE_ONE;
                    w_dir_nxt    = DIR_UP;
                    w_idx_nxt    = '0;
                    w_period_nxt = LP_START;
                    w_step_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SERVE;
            end
        endcase

        // The player who failed to return serves next, parked at their own end.
        if (w_miss) begin
            w_point_one  = (w_rcv == SIDE_TWO);
            w_point_two  = (w_rcv == SIDE_ONE);
            w_server_nxt = w_rcv;
            w_idx_nxt    = (w_rcv == SIDE_ONE) ? '0 : LP_LAST;
            w_period_nxt = LP_START;
            w_step_nxt   = '0;
            w_state_nxt  = SERVE;
        end

        if (match_one || match_two) begin
            w_state_nxt = GAME_OVER;
            w_step_nxt  = '0;
            w_start     = 1'b0;
            w_point_one = 1'b0;
            w_point_two = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= SERVE;
            r_server       <= SIDE_ONE;
            r_dir          <= DIR_UP;
            r_idx          <= '0;
            r_period       <= LP_START;
            r_step         <= '0;
            r_btn_one_prev <= 1'b0;
            r_btn_two_prev <= 1'b0;
            r_press_one    <= 1'b0;
            r_press_two    <= 1'b0;
            r_pos          <= LP_ONE;
        end else begin
            r_state        <= w_state_nxt;
            r_server       <= w_server_nxt;
            r_dir          <= w_dir_nxt;
            r_idx          <= w_idx_nxt;
            r_period       <= w_period_nxt;
            r_step         <= w_step_nxt;
            r_btn_one_prev <= button_one;
            r_btn_two_prev <= button_two;
            r_press_one    <= button_one & ~r_btn_one_prev;
            r_press_two    <= button_two & ~r_btn_two_prev;
            r_pos          <= (r_state == GAME_OVER) ? '1 : (LP_ONE << r_idx);
        end
    end

    assign pos        = r_pos;
    assign start_game = w_start;
    assign point_one  = w_point_one;
    assign point_two  = w_point_two;

endmodule

// File: tb/tb_tennis_ball_ctrl.sv
// Bench for tennis_ball_ctrl (8 LEDs, tick every clk, periods 4 -> floor 2, window 2):
// per-cycle expectation records, queued when driven and compared 1 time unit after the edge.
module tb_tennis_ball_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b1 = 1'b0, b2 = 1'b0, m1 = 1'b0, m2 = 1'b0;
    logic [7:0] pos;
    logic       hittable_one, hittable_two, start_game, point_one, point_two;

    typedef struct packed {
        logic [7:0] pos;
        logic       h1;
        logic       h2;
        logic       sg;
        logic       p1;
        logic       p2;
    } obs_t;

    typedef struct {
        logic  b1;
        logic  b2;
        logic  m1;
        logic  m2;
        int    n;
        obs_t  exp;
        string tag;
    } vec_t;

    vec_t  vec_q[$];
    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    tennis_ball_ctrl #(
        .NUM_LEDS   (8),
        .PRESCALE   (1),
        .START_TICKS(4),
        .MIN_TICKS  (2),
        .SPEED_STEP (1),
        .HIT_WINDOW (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_one  (b1),
        .button_two  (b2),
        .match_one   (m1),
        .match_two   (m2),
        .pos         (pos),
        .hittable_one(hittable_one),
        .hittable_two(hittable_two),
        .start_game  (start_game),
        .point_one   (point_one),
        .point_two   (point_two)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input logic [7:0] p, input logic h1, input logic h2,
                                input logic sg, input logic p1, input logic p2);
        return {p, h1, h2, sg, p1, p2};
    endfunction

    task automatic add(input logic i1, input logic i2, input logic im1, input logic im2,
                       input int n, input obs_t e, input string tag);
        vec_t v;
        v.b1 = i1; v.b2 = i2; v.m1 = im1; v.m2 = im2;
        v.n = n; v.exp = e; v.tag = tag;
        vec_q.push_back(v);
    endtask

    task automatic check(input obs_t e, input string tag);
        obs_t act;
        act = {pos, hittable_one, hittable_two, start_game, point_one, point_two};
        n_checks++;
        if (act === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pos=%h h1=%b h2=%b start=%b p1=%b p2=%b, want pos=%h h1=%b h2=%b start=%b p1=%b p2=%b",
                     tag, act.pos, act.h1, act.h2, act.sg, act.p1, act.p2,
                     e.pos, e.h1, e.h2, e.sg, e.p1, e.p2);
        end
    endtask

    task automatic run_vecs();
        vec_t v;
        while (vec_q.size() > 0) begin
            v = vec_q.pop_front();
            for (int c = 0; c < v.n; c++) begin
                @(negedge clk);
                b1 = v.b1; b2 = v.b2; m1 = v.m1; m2 = v.m2;
                exp_q.push_back(v.exp);
                tag_q.push_back($sformatf("%s[%0d]", v.tag, c));
                @(posedge clk);
                #1;
                check(exp_q.pop_front(), tag_q.pop_front());
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(ex(8'h01, 0, 0, 0, 0, 0), "reset");
        @(negedge clk);
        rst = 1'b0;

        add(0, 0, 0, 0, 50, ex(8'h01, 0, 0, 0, 0, 0), "idle");
        // player one serves; ball climbs one LED per 4 cycles
        add(1, 0, 0, 0, 1, ex(8'h01, 0, 0, 1, 0, 0), "serve1");
        add(1, 0, 0, 0, 5, ex(8'h01, 0, 0, 0, 0, 0), "launch1");
        add(1, 0, 0, 0, 4, ex(8'h02, 0, 0, 0, 0, 0), "up02");
        add(1, 0, 0, 0, 4, ex(8'h04, 0, 0, 0, 0, 0), "up04");
        add(1, 0, 0, 0, 4, ex(8'h08, 0, 0, 0, 0, 0), "up08");
        add(1, 0, 0, 0, 4, ex(8'h10, 0, 0, 0, 0, 0), "up10");
        add(1, 0, 0, 0, 3, ex(8'h20, 0, 0, 0, 0, 0), "up20");
        add(1, 0, 0, 0, 1, ex(8'h20, 0, 1, 0, 0, 0), "win2_open");
        add(1, 0, 0, 0, 4, ex(8'h40, 0, 1, 0, 0, 0), "up40");
        add(0, 0, 0, 0, 1, ex(8'h80, 0, 1, 0, 0, 0), "up80");
        // player two returns at the far end; period drops to 3
        add(0, 1, 0, 0, 1, ex(8'h80, 0, 1, 0, 0, 0), "ret2");
        add(0, 1, 0, 0, 4, ex(8'h80, 0, 0, 0, 0, 0), "ret2_p3");
        add(0, 0, 0, 0, 3, ex(8'h40, 0, 0, 0, 0, 0), "dn40");
        add(0, 0, 0, 0, 3, ex(8'h20, 0, 0, 0, 0, 0), "dn20");
        add(0, 0, 0, 0, 3, ex(8'h10, 0, 0, 0, 0, 0), "dn10");
        add(0, 0, 0, 0, 3, ex(8'h08, 0, 0, 0, 0, 0), "dn08");
        add(0, 0, 0, 0, 2, ex(8'h04, 0, 0, 0, 0, 0), "dn04");
        add(0, 0, 0, 0, 1, ex(8'h04, 1, 0, 0, 0, 0), "win1_open");
        add(0, 0, 0, 0, 3, ex(8'h02, 1, 0, 0, 0, 0), "dn02");
        // player one returns; period reaches the floor of 2
        add(1, 0, 0, 0, 1, ex(8'h01, 1, 0, 0, 0, 0), "ret1");
        add(1, 0, 0, 0, 3, ex(8'h01, 0, 0, 0, 0, 0), "ret1_p2");
        add(0, 0, 0, 0, 2, ex(8'h02, 0, 0, 0, 0, 0), "f_up02");
        add(0, 0, 0, 0, 2, ex(8'h04, 0, 0, 0, 0, 0), "f_up04");
        add(0, 0, 0, 0, 2, ex(8'h08, 0, 0, 0, 0, 0), "f_up08");
        add(0, 0, 0, 0, 2, ex(8'h10, 0, 0, 0, 0, 0), "f_up10");
        add(0, 0, 0, 0, 1, ex(8'h20, 0, 0, 0, 0, 0), "f_up20");
        add(0, 0, 0, 0, 1, ex(8'h20, 0, 1, 0, 0, 0), "f_win2");
        add(0, 0, 0, 0, 2, ex(8'h40, 0, 1, 0, 0, 0), "f_up40");
        // return lands in the cycle a miss step is due: return wins, period stays floored
        add(0, 1, 0, 0, 1, ex(8'h80, 0, 1, 0, 0, 0), "ret2_vs_step");
        add(0, 1, 0, 0, 3, ex(8'h80, 0, 0, 0, 0, 0), "ret2_floor");
        add(0, 0, 0, 0, 2, ex(8'h40, 0, 0, 0, 0, 0), "floor40");
        add(0, 0, 0, 0, 2, ex(8'h20, 0, 0, 0, 0, 0), "floor20");
        add(0, 0, 0, 0, 2, ex(8'h10, 0, 0, 0, 0, 0), "floor10");
        add(0, 0, 0, 0, 2, ex(8'h08, 0, 0, 0, 0, 0), "floor08");
        add(0, 0, 0, 0, 1, ex(8'h04, 0, 0, 0, 0, 0), "floor04");
        add(0, 0, 0, 0, 1, ex(8'h04, 1, 0, 0, 0, 0), "floor04_win");
        add(0, 0, 0, 0, 2, ex(8'h02, 1, 0, 0, 0, 0), "floor02");
        // player one misses: point to two, one serves
        add(0, 0, 0, 0, 1, ex(8'h01, 1, 0, 0, 0, 1), "miss_one");
        add(0, 0, 0, 0, 3, ex(8'h01, 0, 0, 0, 0, 0), "park_one");
        add(0, 1, 0, 0, 3, ex(8'h01, 0, 0, 0, 0, 0), "nonserver_two_ign");
        add(1, 0, 0, 0, 1, ex(8'h01, 0, 0, 1, 0, 0), "serve1b");
        add(0, 0, 0, 0, 5, ex(8'h01, 0, 0, 0, 0, 0), "launch1b");
        add(0, 0, 0, 0, 4, ex(8'h02, 0, 0, 0, 0, 0), "b_up02");
        add(0, 0, 0, 0, 4, ex(8'h04, 0, 0, 0, 0, 0), "b_up04");
        add(0, 0, 0, 0, 4, ex(8'h08, 0, 0, 0, 0, 0), "b_up08");
        add(0, 0, 0, 0, 4, ex(8'h10, 0, 0, 0, 0, 0), "b_up10");
        add(0, 0, 0, 0, 3, ex(8'h20, 0, 0, 0, 0, 0), "b_up20");
        add(0, 0, 0, 0, 1, ex(8'h20, 0, 1, 0, 0, 0), "b_win2");
        add(0, 0, 0, 0, 4, ex(8'h40, 0, 1, 0, 0, 0), "b_up40");
        add(0, 0, 0, 0, 2, ex(8'h80, 0, 1, 0, 0, 0), "b_up80");
        // no return from two: point to one, two serves from the top end
        add(0, 0, 0, 0, 1, ex(8'h80, 0, 1, 0, 1, 0), "miss_two");
        add(0, 0, 0, 0, 3, ex(8'h80, 0, 0, 0, 0, 0), "park_two");
        add(1, 0, 0, 0, 3, ex(8'h80, 0, 0, 0, 0, 0), "nonserver_one_ign");
        add(0, 0, 0, 0, 1, ex(8'h80, 0, 0, 0, 0, 0), "idle_two");
        add(0, 1, 0, 0, 1, ex(8'h80, 0, 0, 1, 0, 0), "serve2");
        add(0, 0, 0, 0, 5, ex(8'h80, 0, 0, 0, 0, 0), "launch2");
        add(0, 0, 0, 0, 4, ex(8'h40, 0, 0, 0, 0, 0), "s2_dn40");
        // match mid-rally: game over, buttons ignored, then back to reset values
        add(0, 0, 0, 1, 1, ex(8'h20, 0, 0, 0, 0, 0), "match_in");
        add(0, 0, 0, 1, 4, ex(8'hFF, 0, 0, 0, 0, 0), "game_over");
        add(1, 0, 0, 1, 2, ex(8'hFF, 0, 0, 0, 0, 0), "go_btn_ign");
        add(0, 0, 0, 0, 1, ex(8'hFF, 0, 0, 0, 0, 0), "match_off");
        add(0, 0, 0, 0, 3, ex(8'h01, 0, 0, 0, 0, 0), "reset_vals");
        add(1, 0, 0, 0, 1, ex(8'h01, 0, 0, 1, 0, 0), "serve_after_go");
        add(0, 0, 0, 0, 5, ex(8'h01, 0, 0, 0, 0, 0), "g_launch");
        add(0, 0, 0, 0, 4, ex(8'h02, 0, 0, 0, 0, 0), "g_up02");
        add(0, 0, 0, 0, 4, ex(8'h04, 0, 0, 0, 0, 0), "g_up04");
`ifdef EARLY_SWING_PENALTY_EN
        add(0, 1, 0, 0, 1, ex(8'h08, 0, 0, 0, 1, 0), "early_swing");
        add(0, 1, 0, 0, 1, ex(8'h08, 0, 0, 0, 0, 0), "early_to_serve");
        add(0, 0, 0, 0, 3, ex(8'h80, 0, 0, 0, 0, 0), "early_park");
        add(0, 1, 0, 0, 1, ex(8'h80, 0, 0, 1, 0, 0), "serve2_after_early");
`else
        add(0, 1, 0, 0, 1, ex(8'h08, 0, 0, 0, 0, 0), "early_ign");
        add(0, 1, 0, 0, 3, ex(8'h08, 0, 0, 0, 0, 0), "early_ign_hold");
        add(0, 0, 0, 0, 4, ex(8'h10, 0, 0, 0, 0, 0), "early_ign_cont");
`endif
        run_vecs();

        // asynchronous reset in the middle of a rally
        @(negedge clk);
        rst = 1'b1;
        #1;
        check(ex(8'h01, 0, 0, 0, 0, 0), "async_rst");
        repeat (2) @(posedge clk);
        #1;
        check(ex(8'h01, 0, 0, 0, 0, 0), "rst_held");
        @(negedge clk);
        rst = 1'b0;
        add(0, 0, 0, 0, 1, ex(8'h01, 0, 0, 0, 0, 0), "post_rst_idle");
        add(1, 0, 0, 0, 1, ex(8'h01, 0, 0, 1, 0, 0), "serve_after_rst");
        add(0, 0, 0, 0, 5, ex(8'h01, 0, 0, 0, 0, 0), "r_launch");
        add(0, 0, 0, 0, 4, ex(8'h02, 0, 0, 0, 0, 0), "r_up02");
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
